// File: rtl/sa_result_collect.sv
//------------------------------------------------------------------------------
// Module      : sa_result_collect
// Description : Snapshots a systolic array's results on cal_done and drains
//               them one word per handshake, row-major, with indices attached.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sa_result_collect #(
    parameter int X  = 3,
    parameter int Y  = 3,
    parameter int RL = 32
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              cal_done,
    input  logic [X*Y*RL-1:0] pe_result,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [RL-1:0]     out_data,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic              out_last,
    output logic              busy,
    output logic              collect_done,
    output logic              err_overrun
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [7:0] c_LAST_ROW = 8'(X - 1);
    localparam logic [7:0] c_LAST_COL = 8'(Y - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [X*Y*RL-1:0]   r_snap;
    logic [7:0]          r_row;
    logic [7:0]          r_col;
    logic [7:0]          w_row_nxt;
    logic [7:0]          w_col_nxt;
    logic                r_collect_done;
    logic                r_err_overrun;

    logic                w_busy;
    logic                w_hs;
    logic                w_at_last;
    logic                w_final;
    logic                w_capture;
    logic                w_overrun;

    always_comb begin
        w_busy    = (r_state == DRAIN);
        w_hs      = w_busy & out_ready;
        w_at_last = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);
        w_final   = w_hs & w_at_last;
        // A new result is only accepted when the engine is free or freeing up now
        w_capture = cal_done & (~w_busy | w_final);
        w_overrun = cal_done & w_busy & ~w_final;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        if (w_capture) begin
            w_state_nxt = DRAIN;
            w_row_nxt   = 8'd0;
            w_col_nxt   = 8'd0;
        end else if (w_final) begin
            w_state_nxt = IDLE;
            w_row_nxt   = 8'd0;
            w_col_nxt   = 8'd0;
        end else if (w_hs) begin
            if (r_col == c_LAST_COL) begin
                w_col_nxt = 8'd0;
                w_row_nxt = r_row + 8'd1;
            end else begin
                w_col_nxt = r_col + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state        <= IDLE;
            r_row          <= 8'd0;
            r_col          <= 8'd0;
            r_collect_done <= 1'b0;
            r_err_overrun  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_row          <= w_row_nxt;
            r_col          <= w_col_nxt;
            r_collect_done <= w_final;
            r_err_overrun  <= r_err_overrun | w_overrun;
        end
    end

    // Snapshot is kept as a shift register: the current element always sits
    // in the low word, so each handshake simply shifts the next one down.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_snap <= '0;
        end else if (w_capture) begin
            r_snap <= pe_result;
        end else if (w_hs) begin
            r_snap <= r_snap >> RL;
        end
    end

    assign busy         = w_busy;
    assign out_valid    = w_busy;
    assign out_data     = w_busy ? r_snap[RL-1:0] : '0;
    assign out_row      = w_busy ? r_row : 8'd0;
    assign out_col      = w_busy ? r_col : 8'd0;
    assign out_last     = w_busy & w_at_last;
    assign collect_done = r_collect_done;
    assign err_overrun  = r_err_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sa_result_collect.sv
//------------------------------------------------------------------------------
// Module      : tb_sa_result_collect
// Description : Scoreboard bench for sa_result_collect (3x3, 32-bit words).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sa_result_collect;

    localparam int X  = 3;
    localparam int Y  = 3;
    localparam int RL = 32;

    logic              clk       = 1'b0;
    logic              sys_rst_n = 1'b1;
    logic              cal_done  = 1'b0;
    logic [X*Y*RL-1:0] pe_result = '0;
    logic              out_ready = 1'b1;
    logic              out_valid;
    logic [RL-1:0]     out_data;
    logic [7:0]        out_row;
    logic [7:0]        out_col;
    logic              out_last;
    logic              busy;
    logic              collect_done;
    logic              err_overrun;

    sa_result_collect #(.X(X), .Y(Y), .RL(RL)) u_dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .cal_done     (cal_done),
        .pe_result    (pe_result),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last     (out_last),
        .busy         (busy),
        .collect_done (collect_done),
        .err_overrun  (err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  row;
        logic [7:0]  col;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every accepted word is compared against the scoreboard head
    always @(negedge clk) begin
        if (sys_rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got data 0x%0h row %0d col %0d, required none",
                         out_data, out_row, out_col);
            end else begin
                mon_e = exp_q.pop_front();
                check("word_data", out_data, mon_e.data);
                check("word_row",  out_row,  mon_e.row);
                check("word_col",  out_col,  mon_e.col);
                check("word_last", out_last, mon_e.last);
            end
        end
    end

    task automatic set_pattern(input logic [31:0] base);
        for (int i = 0; i < X; i++)
            for (int j = 0; j < Y; j++)
                pe_result[(i*Y+j)*RL +: RL] = base + 32'(16*i + j);
    endtask

    task automatic push_pattern(input logic [31:0] base);
        exp_t e;
        for (int i = 0; i < X; i++)
            for (int j = 0; j < Y; j++) begin
                e.data = base + 32'(16*i + j);
                e.row  = 8'(i);
                e.col  = 8'(j);
                e.last = (i == X-1) && (j == Y-1);
                exp_q.push_back(e);
            end
    endtask

    // Leaves the bench 1ns after the edge that sampled cal_done
    task automatic pulse_cal();
        @(posedge clk); #1 cal_done = 1'b1;
        @(posedge clk); #1 cal_done = 1'b0;
    endtask

    task automatic wait_rc(input int r, input int c);
        int n = 0;
        while (!(out_valid && out_row == 8'(r) && out_col == 8'(c)) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_element", 32'(n < 50), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!collect_done && n < 50);
        check("done_seen",       collect_done, 1);
        check("done_valid_low",  out_valid, 0);
        check("done_queue_empty", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
        check("done_one_cycle",  collect_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2 sys_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data",  out_data, 0);
        check("rst_busy",  busy, 0);
        check("rst_last",  out_last, 0);
        check("rst_done",  collect_done, 0);
        check("rst_err",   err_overrun, 0);
        sys_rst_n = 1'b1;

        // Basic drain with latency and collect_done timing
        set_pattern(32'd0);
        push_pattern(32'd0);
        pulse_cal();
        check("lat_valid", out_valid, 1);
        check("lat_data",  out_data, 0);
        check("lat_busy",  busy, 1);
        wait_rc(2, 2);
        check("basic_last", out_last, 1);
        @(posedge clk); #1;
        check("basic_done",  collect_done, 1);
        check("basic_idle",  out_valid, 0);
        check("basic_empty", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
        check("basic_done_clr", collect_done, 0);

        // Backpressure at element (1,1)
        push_pattern(32'd0);
        pulse_cal();
        wait_rc(1, 1);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_data", out_data, 32'd17);
            check("bp_row",  out_row, 1);
            check("bp_col",  out_col, 1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done();

        // Snapshot isolation from later pe_result changes
        push_pattern(32'd0);
        pulse_cal();
        pe_result = '1;
        wait_done();
        set_pattern(32'd0);

        // Back-to-back: cal_done coincident with the final handshake
        push_pattern(32'd0);
        pulse_cal();
        wait_rc(2, 2);
        cal_done = 1'b1;
        set_pattern(32'h100);
        push_pattern(32'h100);
        @(posedge clk); #1 cal_done = 1'b0;
        check("b2b_valid", out_valid, 1);
        check("b2b_data",  out_data, 32'h100);
        check("b2b_row",   out_row, 0);
        check("b2b_col",   out_col, 0);
        check("b2b_done",  collect_done, 1);
        check("b2b_err",   err_overrun, 0);
        wait_done();
        set_pattern(32'd0);

        // Overrun: cal_done while the 4th word is on the output
        push_pattern(32'd0);
        pulse_cal();
        wait_rc(1, 0);
        cal_done = 1'b1;
        @(posedge clk); #1 cal_done = 1'b0;
        check("ovr_err", err_overrun, 1);
        check("ovr_row", out_row, 1);
        check("ovr_col", out_col, 1);
        wait_done();
        repeat (5) begin
            @(posedge clk); #1;
            check("ovr_no_second_drain", out_valid, 0);
        end
        check("ovr_sticky", err_overrun, 1);

        // Reset in the middle of a drain
        push_pattern(32'd0);
        pulse_cal();
        wait_rc(1, 1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data",  out_data, 0);
        check("mid_rst_row",   out_row, 0);
        check("mid_rst_col",   out_col, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_err",   err_overrun, 0);
        exp_q.delete();
        @(posedge clk); #1 sys_rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("post_rst_valid", out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sa_result_collect.md
SA_RESULT_COLLECT -- requirements
Module: sa_result_collect

Interface
REQ-001 Parameter X, default 3: systolic array rows; the range is 1..255.
REQ-002 Parameter Y, default 3: systolic array columns; the range is 1..255.
REQ-003 Parameter RL, default 32: width of one PE result word.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 sys_rst_n  input  1  asynchronous active-low reset.
REQ-006 cal_done  input  1  one-cycle pulse from the array controller; all PE results are final in the cycle it is high.
REQ-007 pe_result  input  X*Y*RL  flattened PE results; row i, column j at bits [(i*Y+j)*RL +: RL].
REQ-008 out_ready  input  1  downstream accepts the word when high together with out_valid.
REQ-009 out_valid  output  1  out_data, out_row, out_col and out_last are valid.
REQ-010 out_data  output  RL  current result word.
REQ-011 out_row  output  8  row index of out_data.
REQ-012 out_col  output  8  column index of out_data.
REQ-013 out_last  output  1  high with out_valid on element (X-1, Y-1) only.
REQ-014 busy  output  1  high while a snapshot is being drained.
REQ-015 collect_done  output  1  one-cycle pulse after the final handshake of a snapshot.
REQ-016 err_overrun  output  1  sticky flag: a cal_done pulse was dropped.

Function
REQ-017 The block has two states, IDLE and DRAIN, with one X*Y*RL snapshot register and row/col counters.
REQ-018 IDLE with cal_done=1: capture the whole of pe_result into the snapshot, set row=col=0 and enter DRAIN on the same edge.
REQ-019 Latency: when cal_done is sampled at edge k, out_valid=1 and out_data=element(0,0) in the cycle after edge k.
REQ-020 In DRAIN, out_valid=1 continuously; out_data=snapshot[row][col], out_row=row, out_col=col.
REQ-021 A handshake is out_valid & out_ready at a rising edge; only a handshake advances col, and at col=Y-1 it wraps col to 0 and increments row (row-major order).
REQ-022 With out_valid=1 and out_ready=0, every output stays stable; there is no timeout.
REQ-023 A handshake on element (X-1, Y-1) returns to IDLE and pulses collect_done high for the next cycle.
REQ-024 busy = (state==DRAIN); out_valid = busy.
REQ-025 Once captured, the snapshot is independent of pe_result; the array may start a new computation immediately.
REQ-026 cal_done in DRAIN without the final handshake in the same cycle: drop the pulse, set err_overrun, and leave the current drain unaffected.
REQ-027 cal_done in the same cycle as the final handshake: recapture the snapshot, reset the counters and stay in DRAIN; collect_done still pulses, and err_overrun is not set.
REQ-028 X=1 and Y=1 is legal: a single element with out_last=1.
REQ-029 Indices are zero-extended into the 8-bit outputs; the counters never exceed X-1 / Y-1.
REQ-030 No arithmetic is performed on data; words pass through bit-exact.

Reset
REQ-031 sys_rst_n=0 forces asynchronously: state IDLE; row=col=0; out_valid, out_last, busy, collect_done and err_overrun at 0; out_data, out_row and out_col at 0.
REQ-032 The snapshot register is cleared to 0 on reset.
REQ-033 A reset mid-DRAIN discards the snapshot; after release, nothing is output until the next cal_done.
REQ-034 err_overrun is cleared only by reset.

Verification
REQ-035 Basic drain: X=Y=3, RL=32, pe_result element (i,j)=16*i+j, out_ready=1, cal_done pulse -> 9 consecutive words 0,1,2,16,17,18,32,33,34; out_last only on 34; collect_done one cycle after the final handshake.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles at element (1,1) -> out_data=17, out_row=1, out_col=1 stable for 5 cycles, then the sequence resumes with 18.
REQ-037 Snapshot isolation: change pe_result to all 0xFFFFFFFF one cycle after cal_done -> the drained values remain the original 0..34 pattern.
REQ-038 Overrun: cal_done at the 4th word -> err_overrun=1 and stays 1; the drain completes normally with 9 words; no second drain follows.
REQ-039 Back-to-back: cal_done coincident with the final handshake -> the next cycle shows out_valid=1, element(0,0) of the new data, collect_done=1 and err_overrun=0.
REQ-040 Reset mid-drain: assert sys_rst_n=0 at word 5 -> all outputs are 0 immediately; after release with no cal_done, out_valid stays 0.
